ws2812_decoder: RTL and testbench
=================================

// Module: ws2812_decoder
// PURPOSE
//  Receive-side counterpart of the ws2812 output path: decodes a synchronised WS2812 serial line into 24-bit GRB words.
//  - Measures each high-pulse width and classifies it as 0/1.
//  - Assembles bits MSB-first into pixels and presents them on a valid/ready stream.
//  - Detects the latch (reset) low period that ends a frame.
//  - Sits after the input synchroniser in loopback and LED-chain capture paths.
// PARAMETERS
//  CNT_W          12    width of high/low cycle counters (saturating)
//  MIN_HIGH_CYC   5     high widths below this are glitches
//  BIT_THRESH_CYC 30    high width >= this decodes as 1, else 0
//  MAX_HIGH_CYC   60    high widths above this are a protocol error
//  RESET_CYC      2500  low cycles that mark frame end (50 us at 50 MHz)
// PORTS
//  i_clk            in   1   clock
//  i_reset_n        in   1   async active-low reset
//  i_signal_synced  in   1   synchronised serial input
//  o_pixel          out  24  decoded word {G,R,B}, G[7] first on wire
//  o_pixel_valid    out  1   o_pixel holds an undelivered word
//  i_pixel_ready    in   1   consumer accepts when valid&ready
//  o_frame_end      out  1   1-cycle pulse on latch detection
//  o_pulse_err      out  1   1-cycle pulse: glitch or over-long high
//  o_partial_err    out  1   1-cycle pulse: frame ended with 1..23 bits pending
//  o_overflow       out  1   1-cycle pulse: pixel dropped (holding reg full)
//  o_pixel_count    out  16  pixels decoded in current frame, saturates 0xFFFF
//  o_dout           out  1   chain forward output (only with WS2812_PASSTHRU_EN)
// BEHAVIOUR
//  - Reset: every output 0, state SYNC, all counters and shift register 0. Async assertion mid-frame discards all state immediately.
//  - Edge detection uses one register r_prev on i_signal_synced.
//    - rise = ~r_prev & in; fall = r_prev & ~in.
//    - High width = number of cycles in is sampled 1.
//  - FSM states:
//    - SYNC: wait for RESET_CYC consecutive low cycles, then go to LOW. No bits are decoded and no o_frame_end is issued on this exit.
//    - LOW: on rise go to HIGH and set high_cnt=1. If low_cnt reaches RESET_CYC: pulse o_frame_end once, clear bit_cnt, pulse o_partial_err if bit_cnt!=0; low_cnt then holds (no repeat pulse).
//    - HIGH: high_cnt++ (saturating). On fall go to LOW and set low_cnt=1; classify w=high_cnt:
//      - w < MIN_HIGH_CYC: o_pulse_err; bit ignored; bit_cnt unchanged.
//      - w > MAX_HIGH_CYC: o_pulse_err; bit_cnt cleared; state goes to SYNC instead of LOW.
//      - otherwise: shift in (w >= BIT_THRESH_CYC); bit_cnt++.
//  - Pixel completion (24th bit), evaluated in the fall cycle:
//    - o_pixel/o_pixel_valid update on the next edge (1-cycle latency from the fall sample); bit_cnt returns to 0.
//    - o_pixel_count increments, saturating at 0xFFFF.
//  - Holding register:
//    - Cleared on the valid&ready handshake.
//    - If valid & ~ready when a pixel completes: the new pixel is dropped, o_overflow pulses, and o_pixel is unchanged.
//    - If valid & ready in the completion cycle: the new pixel loads with no overflow, and valid stays 1.
//  - o_pixel is stable while valid & ~ready.
//  - o_pixel_count clears on the first rise after o_frame_end, so the count stays readable between frames.
//  - A high that is still high when high_cnt saturates is handled by the w > MAX_HIGH_CYC rule at its fall.
// CONFIGURATION
//  - WS2812_PASSTHRU_EN defined:
//    - o_dout exists and models the LED chain: it is 0 while the first pixel of a frame is received.
//    - From the first rise after that pixel completes, until o_frame_end, o_dout = i_signal_synced delayed 1 cycle.
//    - Forwarding stops with o_dout = 0 on o_frame_end or entry to SYNC. Decoding is unaffected.
//  - WS2812_PASSTHRU_EN undefined: o_dout port and its logic are absent.
// TESTING
//  - Defaults, ready=1:
//    - 2600 low cycles, then 24 bits of 0xA5C30F (high 40 = 1, high 20 = 0, period 62) -> one o_pixel=0xA5C30F valid 1 cycle after the 24th fall.
//    - Then 2500 low -> o_frame_end, count=1.
//  - Two pixels 0x000001, 0xFFFFFF with ready=0 -> first held; second gives o_overflow; o_pixel stays 0x000001.
//  - High of 3 cycles mid-pixel -> o_pulse_err; pixel completes with no corruption.
//  - High of 70 cycles -> o_pulse_err; no pixel; needs 2500 low before decoding resumes.
//  - 10 bits then 2500 low -> o_frame_end + o_partial_err; no valid; next frame decodes cleanly.
//  - i_reset_n low at bit 12 -> all outputs 0 asynchronously; post-reset frame decodes correctly.
//  - PASSTHRU_EN: 2-pixel frame -> o_dout low during pixel 1; pixel-2 waveform reproduced 1 cycle late.

Source files
------------

// File: rtl/ws2812_decoder.sv
// WS2812 receive decoder: pulse-width classifies a synchronised serial line into 24-bit GRB words.
// Optional chain pass-through output o_dout is compiled in with `define WS2812_PASSTHRU_EN.
module ws2812_decoder #(
  parameter int CNT_W          = 12,
  parameter int MIN_HIGH_CYC   = 5,
  parameter int BIT_THRESH_CYC = 30,
  parameter int MAX_HIGH_CYC   = 60,
  parameter int RESET_CYC      = 2500
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_signal_synced,
  output logic [23:0] o_pixel,
  output logic        o_pixel_valid,
  input  logic        i_pixel_ready,
  output logic        o_frame_end,
  output logic        o_pulse_err,
  output logic        o_partial_err,
  output logic        o_overflow,
  output logic [15:0] o_pixel_count
`ifdef WS2812_PASSTHRU_EN
  , output logic      o_dout
`endif
);

  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_HIGH_CYC);
  localparam logic [CNT_W-1:0] THR_C   = CNT_W'(BIT_THRESH_CYC);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_HIGH_CYC);
  localparam logic [CNT_W-1:0] RESET_C = CNT_W'(RESET_CYC);

  typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

  state_t           state;
  logic             r_prev;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [4:0]       bit_cnt;
  logic [23:0]      shift;
  logic             frame_done;
  logic             rise, fall, bit_val;
`ifdef WS2812_PASSTHRU_EN
  logic             fwd_arm, fwd_on;
`endif

  assign rise    = ~r_prev & i_signal_synced;
  assign fall    = r_prev & ~i_signal_synced;
  assign bit_val = (high_cnt >= THR_C);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= SYNC;
      r_prev        <= 1'b0;
      low_cnt       <= '0;
      high_cnt      <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      frame_done    <= 1'b0;
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
      o_frame_end   <= 1'b0;
      o_pulse_err   <= 1'b0;
      o_partial_err <= 1'b0;
      o_overflow    <= 1'b0;
      o_pixel_count <= '0;
`ifdef WS2812_PASSTHRU_EN
      fwd_arm       <= 1'b0;
      fwd_on        <= 1'b0;
      o_dout        <= 1'b0;
`endif
    end else begin
      r_prev        <= i_signal_synced;
      o_frame_end   <= 1'b0;
      o_pulse_err   <= 1'b0;
      o_partial_err <= 1'b0;
      o_overflow    <= 1'b0;
      if (o_pixel_valid && i_pixel_ready) o_pixel_valid <= 1'b0;
`ifdef WS2812_PASSTHRU_EN
      // forwarding starts on the rise that follows the first completed pixel
      o_dout <= (fwd_on || (fwd_arm && rise)) ? i_signal_synced : 1'b0;
`endif
      case (state)
        SYNC: begin
          if (i_signal_synced) low_cnt <= '0;
          else if (low_cnt >= RESET_C - 1'b1) begin
            low_cnt <= RESET_C;
            state   <= LOW;
          end else low_cnt <= low_cnt + 1'b1;
        end
        LOW: begin
          if (rise) begin
            state    <= HIGH;
            high_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            if (frame_done) begin
              o_pixel_count <= '0;
              frame_done    <= 1'b0;
            end
`ifdef WS2812_PASSTHRU_EN
            if (fwd_arm) fwd_on <= 1'b1;
`endif
          end else if (!i_signal_synced && low_cnt < RESET_C) begin
            low_cnt <= low_cnt + 1'b1;
            if (low_cnt == RESET_C - 1'b1) begin
              o_frame_end   <= 1'b1;
              o_partial_err <= (bit_cnt != 5'd0);
              bit_cnt       <= '0;
              frame_done    <= 1'b1;
`ifdef WS2812_PASSTHRU_EN
              fwd_arm <= 1'b0;
              fwd_on  <= 1'b0;
              o_dout  <= 1'b0;
`endif
            end
          end
        end
        HIGH: begin
          if (fall) begin
            low_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            state   <= LOW;
            if (high_cnt < MIN_C) begin
              o_pulse_err <= 1'b1;
            end else if (high_cnt > MAX_C) begin
              // over-long high: lose bit alignment until a fresh latch period
              o_pulse_err <= 1'b1;
              bit_cnt     <= '0;
              low_cnt     <= {{(CNT_W-1){1'b0}}, 1'b1};
              state       <= SYNC;
`ifdef WS2812_PASSTHRU_EN
              fwd_arm <= 1'b0;
              fwd_on  <= 1'b0;
              o_dout  <= 1'b0;
`endif
            end else begin
              shift <= {shift[22:0], bit_val};
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                if (o_pixel_count != 16'hFFFF) o_pixel_count <= o_pixel_count + 16'd1;
`ifdef WS2812_PASSTHRU_EN
                fwd_arm <= 1'b1;
`endif
                if (!o_pixel_valid || i_pixel_ready) begin
                  o_pixel       <= {shift[22:0], bit_val};
                  o_pixel_valid <= 1'b1;
                end else begin
                  o_overflow <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end else if (high_cnt != {CNT_W{1'b1}}) begin
            high_cnt <= high_cnt + 1'b1;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_decoder.sv
// Scoreboard bench for ws2812_decoder: a pulse-level model pushes expected pixels/frame ends,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_ws2812_decoder;

  logic        clk = 1'b0;
  logic        rst_n, sig, ready;
  logic [23:0] pixel;
  logic        valid, frame_end, pulse_err, partial_err, overflow;
  logic [15:0] count;
`ifdef WS2812_PASSTHRU_EN
  logic        dout;
`endif

  ws2812_decoder dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_signal_synced(sig),
    .o_pixel(pixel), .o_pixel_valid(valid), .i_pixel_ready(ready),
    .o_frame_end(frame_end), .o_pulse_err(pulse_err), .o_partial_err(partial_err),
    .o_overflow(overflow), .o_pixel_count(count)
`ifdef WS2812_PASSTHRU_EN
    , .o_dout(dout)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int n_perr = 0, n_ovf = 0, exp_perr = 0, exp_ovf = 0;
  logic [23:0] exp_px[$];
  int          exp_fe[$];
  bit          exp_part[$];

  // reference model state
  bit          decoding = 0, fe_seen = 0, held = 0, cnt_known = 1;
  int          pend = 0, frame_px = 0;
  logic [23:0] acc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input int n);
    sig = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_bit(input int hi);
    if (!decoding) return;
    if (hi < 5) exp_perr++;
    else if (hi > 60) begin exp_perr++; decoding = 0; pend = 0; end
    else begin
      acc = {acc[22:0], (hi >= 30)};
      pend++;
      if (pend == 24) begin
        pend = 0;
        frame_px++;
        if (ready) exp_px.push_back(acc);
        else if (held) exp_ovf++;
        else begin exp_px.push_back(acc); held = 1; end
      end
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    if (decoding && fe_seen) begin frame_px = 0; fe_seen = 0; end
    drive(1'b1, hi);
    model_bit(hi);
    drive(1'b0, lo);
  endtask

  task automatic latch(input int n);
    if (!decoding) begin
      if (n >= 2500) decoding = 1;
    end else if (n >= 2500) begin
      exp_fe.push_back(cnt_known ? frame_px : -1);
      exp_part.push_back(pend != 0);
      pend = 0;
      fe_seen = 1;
      cnt_known = 1;
    end
    drive(1'b0, n);
  endtask

  task automatic send_px(input logic [23:0] px, input bit fixed);
    for (int i = 23; i >= 0; i--) begin
      if (fixed) pulse(px[i] ? 40 : 20, px[i] ? 22 : 42);
      else pulse(px[i] ? $urandom_range(32, 55) : $urandom_range(8, 25), $urandom_range(8, 30));
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_pixel"}, pixel, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_flags"}, {frame_end, pulse_err, partial_err, overflow}, 0);
  endtask

  // monitor
  always @(negedge clk) begin
    if (valid && ready) begin
      if (exp_px.size() == 0) chk("unexpected_pixel", pixel, 32'hDEAD_BEEF);
      else chk("pixel", pixel, exp_px.pop_front());
    end
    if (frame_end) begin
      if (exp_fe.size() == 0) chk("unexpected_frame_end", 1, 0);
      else begin
        automatic int c = exp_fe.pop_front();
        if (c >= 0) chk("frame_count", count, c);
        chk("partial_err", partial_err, exp_part.pop_front());
      end
    end
    if (pulse_err) n_perr++;
    if (overflow) n_ovf++;
  end

`ifdef WS2812_PASSTHRU_EN
  logic sig_d = 1'b0;
  bit   pt_on = 0, pt_fwd = 0;
  int   pt_err = 0, pt_hi = 0;
  always @(posedge clk) sig_d <= sig;
  always @(negedge clk) if (pt_on) begin
    if (dout !== (pt_fwd ? sig_d : 1'b0)) pt_err++;
    if (dout === 1'b1) pt_hi++;
  end
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] p;
    logic [3:0]  bw;
    int          widths[4];
    rst_n = 1'b0; sig = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst_n = 1'b1;
    latch(2600);

    // fixed-timing pixel with latency check on the 24th fall
    p = 24'hA5C30F;
    for (int i = 23; i >= 1; i--) pulse(p[i] ? 40 : 20, p[i] ? 22 : 42);
    drive(1'b1, 40);
    model_bit(40);
    chk("valid_before_fall", valid, 0);
    sig = 1'b0;
    @(posedge clk); #1;
    chk("valid_after_fall", valid, 1);
    chk("pixel_after_fall", pixel, 24'hA5C30F);
    drive(1'b0, 21);
    latch(2500);

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      for (int k = $urandom_range(1, 2); k > 0; k--) send_px($urandom, 0);
      latch(2500 + $urandom_range(0, 50));
    end

    // width boundaries (5,29 -> 0; 30,60 -> 1) plus two glitches mid-pixel
    widths = '{5, 29, 30, 60};
    for (int i = 0; i < 24; i++) begin
      if (i == 10) begin pulse(3, 20); pulse(4, 20); end
      pulse(widths[i % 4], 20);
    end
    latch(2500);
    chk("perr_glitch", n_perr, exp_perr);

    // backpressure overflow
    ready = 1'b0; cnt_known = 0;
    send_px(24'h000001, 0);
    send_px(24'hFFFFFF, 0);
    chk("ovf_pixel_held", pixel, 24'h000001);
    chk("ovf_valid", valid, 1);
    chk("ovf_count", n_ovf, exp_ovf);
    ready = 1'b1; held = 0;
    latch(2500);

    // over-long high forces resync
    pulse(70, 100);
    send_px($urandom, 0);
    latch(2600);
    send_px($urandom, 0);
    latch(2500);
    chk("perr_overlong", n_perr, exp_perr);

    // partial frame
    for (int i = 0; i < 10; i++) begin
      bw = 4'($urandom_range(0, 1));
      pulse(bw[0] ? 40 : 20, 22);
    end
    latch(2500);
    send_px($urandom, 0);
    latch(2500);

    // async reset mid-pixel
    send_px($urandom, 0);
    for (int i = 0; i < 12; i++) pulse(20, 42);
    sig = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle("async_reset");
    decoding = 0; pend = 0; fe_seen = 0; frame_px = 0; held = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    latch(2600);
    send_px($urandom, 0);
    latch(2500);

`ifdef WS2812_PASSTHRU_EN
    pt_on = 1;
    send_px($urandom, 1);
    pt_fwd = 1;
    send_px($urandom, 1);
    latch(2500);
    pt_fwd = 0; pt_on = 0;
    chk("dout_mismatches", pt_err, 0);
    chk("dout_forwarded", pt_hi > 0, 1);
`endif

    repeat (5) @(posedge clk);
    chk("perr_total", n_perr, exp_perr);
    chk("ovf_total", n_ovf, exp_ovf);
    chk("pixels_left", exp_px.size(), 0);
    chk("frame_ends_left", exp_fe.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
